// File: rtl/layer_mac_sequencer_pkg.sv
// Shared types and constants for the fully-connected layer MAC sequencer.
// The manager's accumulator count fixes the outputs per pass at 8.
package layer_mac_sequencer_pkg;

  localparam int MGR_N_OUTPUTS = 8;

  typedef enum logic [2:0] {
    IDLE,
    CLR,
    FETCH,
    DRAIN,
    FLUSH,
    WAIT_FIN,
    DONE
  } state_e;

  // Ceiling log2 that never returns less than one bit, so one-entry RAMs still get an address port.
  function automatic int clog2(input int value);
    int width;
    width = 1;
    while ((1 << width) < value) width++;
    return width;
  endfunction

endpackage

// File: rtl/layer_mac_sequencer_valid_delay_line.sv
// Shift register that delays the fetch-issue flag by the RAM read latency,
// so its output marks the cycle in which read data is valid.
module valid_delay_line #(
  parameter int DEPTH = 1
) (
  input  logic clock,
  input  logic clear_n,
  input  logic valid_in,
  output logic valid_out
);

  logic [DEPTH-1:0] sr_q;
  logic [DEPTH-1:0] sr_d;

  always_comb begin
    sr_d    = '0;
    sr_d[0] = valid_in;
    for (int i = 1; i < DEPTH; i++) begin
      sr_d[i] = sr_q[i-1];
    end
  end

  // NOTE: unlike a data pipeline, these valid bits must be reset; a stale bit
  // would produce a phantom accumulate strobe after a mid-pass reset.
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign valid_out = sr_q[DEPTH-1];

endmodule

// File: rtl/layer_mac_sequencer.sv
// Sequences one fully-connected layer pass: clears the output manager, streams
// activation/weight reads in output-interleaved order, flushes 8 results, reports done.
module layer_mac_sequencer
  import layer_mac_sequencer_pkg::*;
#(
  parameter int N_INPUTS  = 16,
  parameter int N_OUTPUTS = MGR_N_OUTPUTS,
  parameter int RD_LAT    = 1,
  parameter int IN_AW     = clog2(N_INPUTS),
  parameter int W_AW      = clog2(N_INPUTS * N_OUTPUTS)
) (
  input  logic             clock,
  input  logic             clear_n,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [IN_AW-1:0] input_ram_address,
  output logic             input_ram_enable,
  output logic [W_AW-1:0]  weight_ram_address,
  output logic             weight_ram_enable,
  output logic             mgr_clear,
  output logic             mgr_en,
  output logic             next_element,
  output logic             last_element,
  input  logic             mgr_finished
);

  localparam int              E_W        = W_AW + 1;
  localparam logic [E_W-1:0]  E_LAST     = E_W'(N_INPUTS * N_OUTPUTS - 1);
  localparam logic [2:0]      DRAIN_LAST = 3'(RD_LAT - 1);
  localparam logic [2:0]      FLUSH_LAST = 3'(N_OUTPUTS - 1);

  state_e           state_q, state_d;
  logic [E_W-1:0]   e_q, e_d;
  logic [2:0]       cnt_q, cnt_d;

  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [IN_AW-1:0] input_ram_address_q, input_ram_address_d;
  logic             input_ram_enable_q, input_ram_enable_d;
  logic [W_AW-1:0]  weight_ram_address_q, weight_ram_address_d;
  logic             weight_ram_enable_q, weight_ram_enable_d;
  logic             mgr_clear_q, mgr_clear_d;
  logic             mgr_en_q, mgr_en_d;
  logic             last_element_q, last_element_d;

  // NOTE: every signal gets a default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    e_d     = e_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      IDLE: begin
        if (start) state_d = CLR;
      end
      CLR: begin
        e_d     = '0;
        cnt_d   = '0;
        state_d = FETCH;
      end
      FETCH: begin
        if (e_q == E_LAST) begin
          cnt_d   = '0;
          state_d = DRAIN;
        end else begin
          e_d = e_q + 1'b1;
        end
      end
      DRAIN: begin
        if (cnt_q == DRAIN_LAST) begin
          cnt_d   = '0;
          state_d = FLUSH;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      FLUSH: begin
        if (cnt_q == FLUSH_LAST) begin
          state_d = WAIT_FIN;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      WAIT_FIN: begin
        if (mgr_finished) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Outputs are decoded from the state being entered, so the registered
    // copies line up with the state they describe.
    busy_d               = (state_d != IDLE);
    mgr_en_d             = (state_d != IDLE);
    mgr_clear_d          = (state_d == CLR);
    input_ram_enable_d   = (state_d == FETCH);
    weight_ram_enable_d  = (state_d == FETCH);
    last_element_d       = (state_d == FLUSH);
    done_d               = (state_d == DONE);
    weight_ram_address_d = '0;
    input_ram_address_d  = '0;
    if (state_d == FETCH) begin
      weight_ram_address_d = W_AW'(e_d);
      input_ram_address_d  = IN_AW'(e_d >> 3);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples its pre-edge value regardless of statement order.
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      state_q              <= IDLE;
      e_q                  <= '0;
      cnt_q                <= '0;
      busy_q               <= 1'b0;
      done_q               <= 1'b0;
      input_ram_address_q  <= '0;
      input_ram_enable_q   <= 1'b0;
      weight_ram_address_q <= '0;
      weight_ram_enable_q  <= 1'b0;
      mgr_clear_q          <= 1'b0;
      mgr_en_q             <= 1'b0;
      last_element_q       <= 1'b0;
    end else begin
      state_q              <= state_d;
      e_q                  <= e_d;
      cnt_q                <= cnt_d;
      busy_q               <= busy_d;
      done_q               <= done_d;
      input_ram_address_q  <= input_ram_address_d;
      input_ram_enable_q   <= input_ram_enable_d;
      weight_ram_address_q <= weight_ram_address_d;
      weight_ram_enable_q  <= weight_ram_enable_d;
      mgr_clear_q          <= mgr_clear_d;
      mgr_en_q             <= mgr_en_d;
      last_element_q       <= last_element_d;
    end
  end

  // The issue flag is the registered read enable, so the delayed copy lands
  // exactly RD_LAT cycles after each address leaves this block.
  valid_delay_line #(
    .DEPTH(RD_LAT)
  ) u_valid_delay_line (
    .clock    (clock),
    .clear_n  (clear_n),
    .valid_in (input_ram_enable_q),
    .valid_out(next_element)
  );

  assign busy               = busy_q;
  assign done               = done_q;
  assign input_ram_address  = input_ram_address_q;
  assign input_ram_enable   = input_ram_enable_q;
  assign weight_ram_address = weight_ram_address_q;
  assign weight_ram_enable  = weight_ram_enable_q;
  assign mgr_clear          = mgr_clear_q;
  assign mgr_en             = mgr_en_q;
  assign last_element       = last_element_q;

endmodule

// File: tb/tb_layer_mac_sequencer.sv
// Self-checking bench: two sequencer instances (N=2/RD_LAT=1 and N=1/RD_LAT=3)
// driving RAM and output-manager models; results checked against dot products.
module tb_layer_mac_sequencer;

  typedef struct {
    int c;
    bit busy, done, ien, wen, clr, en, ne, le;
    int ia, wa;
  } sample_t;

  typedef struct {
    int inst;
    int hold;
    bit start_hold;
    int exp_lat;
  } pass_t;

  logic       clock = 1'b0;
  logic       clear_n;
  logic [1:0] start = 2'b00;
  logic [1:0] fin   = 2'b00;
  wire  [1:0] busy, done, ien, wen, mclr, men, ne, le;
  wire  [0:0] ia0, ia1;
  wire  [3:0] wa0;
  wire  [2:0] wa1;

  always #5 clock = ~clock;

  layer_mac_sequencer #(.N_INPUTS(2), .RD_LAT(1)) dut0 (
    .clock(clock), .clear_n(clear_n), .start(start[0]), .busy(busy[0]), .done(done[0]),
    .input_ram_address(ia0), .input_ram_enable(ien[0]),
    .weight_ram_address(wa0), .weight_ram_enable(wen[0]),
    .mgr_clear(mclr[0]), .mgr_en(men[0]), .next_element(ne[0]), .last_element(le[0]),
    .mgr_finished(fin[0])
  );

  layer_mac_sequencer #(.N_INPUTS(1), .RD_LAT(3)) dut1 (
    .clock(clock), .clear_n(clear_n), .start(start[1]), .busy(busy[1]), .done(done[1]),
    .input_ram_address(ia1), .input_ram_enable(ien[1]),
    .weight_ram_address(wa1), .weight_ram_enable(wen[1]),
    .mgr_clear(mclr[1]), .mgr_en(men[1]), .next_element(ne[1]), .last_element(le[1]),
    .mgr_finished(fin[1])
  );

  const int nin[2] = '{2, 1};
  const int lat[2] = '{1, 3};

  longint  zmem[2][16];
  longint  wmem[2][128];
  longint  acc[2][8];
  longint  out_ram[2][8];
  longint  pz[2][4];
  longint  pm[2][4];
  int      ptr[2]       = '{0, 0};
  int      wptr[2]      = '{0, 0};
  int      hold_left[2] = '{0, 0};
  int      hold_cfg[2]  = '{0, 0};
  sample_t trace[2][$];
  int      gcyc = 0;
  int      n_checks = 0;
  int      n_fail = 0;
  int      cur_pass = 0;

  always @(posedge clock) gcyc++;

  function automatic int addr_of(input int k, input bit want_w);
    if (k == 0) return want_w ? int'(wa0) : int'(ia0);
    return want_w ? int'(wa1) : int'(ia1);
  endfunction

  // RAM + output-manager environment and trace recorder, evaluated mid-cycle.
  always @(negedge clock) begin
    for (int k = 0; k < 2; k++) begin
      sample_t s;
      s.c = gcyc; s.busy = busy[k]; s.done = done[k]; s.ien = ien[k]; s.wen = wen[k];
      s.clr = mclr[k]; s.en = men[k]; s.ne = ne[k]; s.le = le[k];
      s.ia = addr_of(k, 1'b0); s.wa = addr_of(k, 1'b1);
      trace[k].push_back(s);
      if (clear_n) begin
        if (mclr[k]) begin
          for (int j = 0; j < 8; j++) acc[k][j] = 0;
          ptr[k] = 0; wptr[k] = 0; fin[k] = 1'b0; hold_left[k] = hold_cfg[k];
        end else begin
          if (ne[k]) begin
            acc[k][ptr[k]] += pz[k][lat[k]-1] * pm[k][lat[k]-1];
            ptr[k] = (ptr[k] + 1) % 8;
          end
          if (le[k] && wptr[k] < 8) begin
            out_ram[k][wptr[k]] = acc[k][wptr[k]];
            wptr[k]++;
            if (wptr[k] == 8 && hold_left[k] == 0) fin[k] = 1'b1;
          end else if (wptr[k] == 8 && !fin[k]) begin
            if (hold_left[k] > 0) hold_left[k]--;
            if (hold_left[k] == 0) fin[k] = 1'b1;
          end
        end
        for (int d = 3; d > 0; d--) begin
          pz[k][d] = pz[k][d-1];
          pm[k][d] = pm[k][d-1];
        end
        pz[k][0] = ien[k] ? zmem[k][s.ia] : 0;
        pm[k][0] = wen[k] ? wmem[k][s.wa] : 0;
      end
    end
  end

  task automatic check(input string name, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL [pass %0d] %s: got %0d, expected %0d", cur_pass, name, got, exp);
    end
  endtask

  function automatic int outs_word(input int k);
    int w;
    w = int'({busy[k], done[k], ien[k], wen[k], mclr[k], men[k], ne[k], le[k]});
    return (w << 8) | (addr_of(k, 1'b0) << 4) | addr_of(k, 1'b1);
  endfunction

  function automatic longint ref_out(input int k, input int j);
    longint sum = 0;
    for (int i = 0; i < nin[k]; i++) sum += zmem[k][i] * wmem[k][i*8 + j];
    return sum;
  endfunction

  function automatic int exp_latency(input int k, input int h);
    int w;
    w = (h == 0) ? 1 : h;
    return 1 + 1 + 8 * nin[k] + lat[k] + 8 + w + 1;
  endfunction

  task automatic fill_random(input int k);
    for (int i = 0; i < nin[k]; i++) zmem[k][i] = longint'($urandom_range(0, 65535));
    for (int i = 0; i < nin[k] * 8; i++) wmem[k][i] = longint'($urandom_range(0, 65535));
  endtask

  task automatic wait_done(input int k, input bit drop_start, output bit seen);
    seen = 1'b0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clock);
      if (drop_start) start[k] = 1'b0;
      if (done[k]) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic run_pass(input int k, input int h, input bit start_hold, input int exp_lat);
    int base, done_c, t0, n, l, r;
    int n_clr, clr_c, n_fetch, f_first, addr_err, n_ne, ne_first, ne_last;
    int n_le, le_first, le_last, n_done, busy_low, ovl, dclr;
    bit seen;
    sample_t s;
    cur_pass++;
    n = nin[k]; l = lat[k];
    hold_cfg[k] = h;
    t0 = trace[k].size();
    @(negedge clock);
    base = gcyc;
    start[k] = 1'b1;
    wait_done(k, !start_hold, seen);
    check("done_seen", longint'(seen), 1);
    if (!seen) begin
      start[k] = 1'b0;
      return;
    end
    done_c = gcyc - base;
    check("start_to_done_latency", done_c + 1, exp_lat);
    @(negedge clock);
    check("busy_after_done", busy[k], 0);
    if (start_hold) begin
      @(negedge clock);
      check("restart_clear_after_idle", mclr[k], 1);
      wait_done(k, 1'b0, seen);
      check("second_done_seen", longint'(seen), 1);
      start[k] = 1'b0;
      @(negedge clock);
      @(negedge clock);
    end

    n_clr = 0; clr_c = -1; n_fetch = 0; f_first = -1; addr_err = 0;
    n_ne = 0; ne_first = -1; ne_last = -1; n_le = 0; le_first = -1; le_last = -1;
    n_done = 0; busy_low = 0; ovl = 0; dclr = 0;
    for (int i = t0; i < trace[k].size(); i++) begin
      s = trace[k][i];
      r = s.c - base;
      if (s.ne && s.le) ovl++;
      if (s.done && s.clr) dclr++;
      if (r < 0 || r > done_c) continue;
      if (r >= 1 && (!s.busy || !s.en)) busy_low++;
      if (s.clr) begin n_clr++; clr_c = r; end
      if (s.ien) begin
        if (f_first < 0) f_first = r;
        if (!s.wen || s.wa != n_fetch || s.ia != n_fetch / 8) addr_err++;
        n_fetch++;
      end
      if (s.ne) begin if (ne_first < 0) ne_first = r; ne_last = r; n_ne++; end
      if (s.le) begin if (le_first < 0) le_first = r; le_last = r; n_le++; end
      if (s.done) n_done++;
    end
    check("clear_pulses", n_clr, 1);
    check("clear_cycle", clr_c, 1);
    check("fetch_first_cycle", f_first, 2);
    check("fetch_count", n_fetch, 8 * n);
    check("fetch_address_errors", addr_err, 0);
    check("next_element_first", ne_first, 2 + l);
    check("next_element_count", n_ne, 8 * n);
    check("next_element_span", ne_last - ne_first, 8 * n - 1);
    check("last_element_first", le_first, 8 * n + l + 2);
    check("last_element_count", n_le, 8);
    check("last_element_last", le_last, 8 * n + l + 9);
    check("done_pulses", n_done, 1);
    check("busy_or_en_low_in_pass", busy_low, 0);
    check("next_last_overlap", ovl, 0);
    check("done_with_clear", dclr, 0);
    for (int j = 0; j < 8; j++) check($sformatf("out_ram[%0d]", j), out_ram[k][j], ref_out(k, j));
  endtask

  pass_t table_v[5];

  initial begin
    bit seen;
    table_v[0] = '{inst: 0, hold: 0,  start_hold: 1'b0, exp_lat: 29};
    table_v[1] = '{inst: 1, hold: 0,  start_hold: 1'b0, exp_lat: 23};
    table_v[2] = '{inst: 0, hold: 20, start_hold: 1'b0, exp_lat: 48};
    table_v[3] = '{inst: 0, hold: 0,  start_hold: 1'b1, exp_lat: 29};
    table_v[4] = '{inst: 1, hold: 5,  start_hold: 1'b0, exp_lat: 27};

    // Reset held with start asserted: everything stays quiet.
    clear_n = 1'b0;
    start   = 2'b11;
    repeat (3) begin
      @(negedge clock);
      for (int k = 0; k < 2; k++) check($sformatf("reset_outputs_%0d", k), outs_word(k), 0);
    end
    start   = 2'b00;
    clear_n = 1'b1;
    repeat (3) begin
      @(negedge clock);
      for (int k = 0; k < 2; k++) check($sformatf("idle_after_reset_%0d", k), outs_word(k), 0);
    end

    // Directed nominal pass: z={3,5}, m[i*8+j]=j+1 gives 8*(j+1).
    zmem[0][0] = 3;
    zmem[0][1] = 5;
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 8; j++) wmem[0][i*8 + j] = j + 1;
    run_pass(0, 0, 1'b0, 29);
    for (int j = 0; j < 8; j++) check($sformatf("nominal_w[%0d]", j), out_ram[0][j], 8 * (j + 1));

    for (int t = 0; t < 5; t++) begin
      fill_random(table_v[t].inst);
      run_pass(table_v[t].inst, table_v[t].hold, table_v[t].start_hold, table_v[t].exp_lat);
    end

    // Reset pulsed while the element counter sits at 5.
    cur_pass++;
    @(negedge clock);
    start[0] = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clock);
      start[0] = 1'b0;
      if (ien[0] && wa0 == 4'd5) begin
        seen = 1'b1;
        break;
      end
    end
    check("reached_e5", longint'(seen), 1);
    clear_n = 1'b0;
    #1;
    check("midpass_reset_outputs", outs_word(0), 0);
    @(negedge clock);
    clear_n = 1'b1;
    @(negedge clock);
    check("idle_after_midpass_reset", busy[0], 0);
    fill_random(0);
    run_pass(0, 0, 1'b0, 29);

    for (int t = 0; t < 4; t++) begin
      int k, h;
      k = int'($urandom_range(0, 1));
      h = int'($urandom_range(0, 6));
      fill_random(k);
      run_pass(k, h, 1'b0, exp_latency(k, h));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", gcyc);
    $fatal(1, "watchdog");
  end

endmodule
